// File: rtl/regfile_debug_scanner_if.sv
// Debug-port and character-write bus between the scanner, the register file and the text buffer.
// Master is the scanner side; slave is the register file / character RAM side.
interface regfile_debug_scanner_if;
   logic [4:0]  dbg_read_address;
   logic        dbg_clock;
   logic [31:0] dbg_data;
   logic        char_valid;
   logic        char_ready;
   logic [4:0]  char_row;
   logic [6:0]  char_col;
   logic [7:0]  char_code;

   modport master (
      output dbg_read_address, dbg_clock, char_valid, char_row, char_col, char_code,
      input  dbg_data, char_ready
   );

   modport slave (
      input  dbg_read_address, dbg_clock, char_valid, char_row, char_col, char_code,
      output dbg_data, char_ready
   );
endinterface

// File: rtl/regfile_debug_scanner.sv
// Sweeps registers through the debug port and writes each word as 8 hex chars into the text buffer.
// 11+SETTLE_CYCLES cycles per register with ready high; a low char_ready freezes the current character.
module regfile_debug_scanner #(
   parameter int NUM_REGS      = 32,
   parameter int COL_BASE      = 4,
   parameter int SETTLE_CYCLES = 1
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    start,
   output logic                    busy,
   output logic                    done,
   regfile_debug_scanner_if.master bus
);
   typedef enum logic [2:0] {S_IDLE, S_ADDR, S_STROBE, S_WAIT, S_EMIT, S_NEXT} state_t;

   localparam logic [4:0] LAST_REG = 5'(NUM_REGS - 1);
   localparam logic [6:0] COL0     = 7'(COL_BASE);
   localparam logic [3:0] SETTLE   = 4'(SETTLE_CYCLES);

   state_t      state, state_nxt;
   logic [4:0]  index;
   logic [2:0]  nibble;
   logic [31:0] data;
   logic [3:0]  settle;
   logic        accept;
   logic        last_reg;
   logic        start_ok;
   logic [31:0] next_word;

   function automatic logic [7:0] hex_char(input logic [3:0] n);
      return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
   endfunction

   assign accept    = bus.char_valid && bus.char_ready;
   assign last_reg  = (index == LAST_REG);
   // A start coinciding with the done pulse belongs to the sweep just finished and is dropped.
   assign start_ok  = start && !done;
   assign next_word = data << {nibble + 3'd1, 2'b00};

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:   if (start_ok) state_nxt = S_ADDR;
         S_ADDR:   state_nxt = S_STROBE;
         S_STROBE: state_nxt = S_WAIT;
         S_WAIT:   if (settle <= 4'd1) state_nxt = S_EMIT;
         S_EMIT:   if (accept && nibble == 3'd7) state_nxt = S_NEXT;
         S_NEXT:   state_nxt = last_reg ? S_IDLE : S_ADDR;
         default:  state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         index                <= '0;
         nibble               <= '0;
         data                 <= '0;
         settle               <= '0;
         bus.dbg_read_address <= '0;
         bus.dbg_clock        <= 1'b1;
         bus.char_valid       <= 1'b0;
         bus.char_row         <= '0;
         bus.char_col         <= '0;
         bus.char_code        <= '0;
         busy                 <= 1'b0;
         done                 <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start_ok) begin
                  index <= '0;
                  busy  <= 1'b1;
               end
            end
            S_ADDR: begin
               bus.dbg_read_address <= index;
               bus.dbg_clock        <= 1'b1;
            end
            S_STROBE: begin
               bus.dbg_clock <= 1'b0;
               settle        <= SETTLE;
            end
            S_WAIT: begin
               settle <= settle - 4'd1;
               if (settle <= 4'd1) begin
                  data           <= bus.dbg_data;
                  nibble         <= '0;
                  bus.char_valid <= 1'b1;
                  bus.char_row   <= index;
                  bus.char_col   <= COL0;
                  bus.char_code  <= hex_char(bus.dbg_data[31:28]);
               end
            end
            S_EMIT: begin
               // Character outputs only move on an accepted write, so they hold through stalls.
               if (accept) begin
                  nibble <= nibble + 3'd1;
                  if (nibble == 3'd7) begin
                     bus.char_valid <= 1'b0;
                  end else begin
                     bus.char_col  <= bus.char_col + 7'd1;
                     bus.char_code <= hex_char(next_word[31:28]);
                  end
               end
            end
            S_NEXT: begin
               bus.dbg_clock <= 1'b1;
               if (last_reg) begin
                  done <= 1'b1;
                  busy <= 1'b0;
               end else begin
                  index <= index + 5'd1;
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_regfile_debug_scanner.sv
// Scoreboard bench: two scanner instances (32 regs/settle 1, 8 regs/settle 4) against a register file model.
module tb_regfile_debug_scanner;
   typedef struct packed {
      logic [4:0] row;
      logic [6:0] col;
      logic [7:0] code;
   } ch_t;

   logic clock = 1'b0;
   logic reset;
   logic start1, start2;
   logic busy1, done1, busy2, done2;
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   bit   rand_mode = 1'b0;

   regfile_debug_scanner_if b1 ();
   regfile_debug_scanner_if b2 ();

   regfile_debug_scanner #(.NUM_REGS(32), .COL_BASE(4), .SETTLE_CYCLES(1)) dut1 (
      .clock(clock), .reset(reset), .start(start1), .busy(busy1), .done(done1), .bus(b1.master));
   regfile_debug_scanner #(.NUM_REGS(8), .COL_BASE(4), .SETTLE_CYCLES(4)) dut2 (
      .clock(clock), .reset(reset), .start(start2), .busy(busy2), .done(done2), .bus(b2.master));

   always #5 clock = ~clock;
   always @(posedge clock) cyc++;

   ch_t q1[$];
   ch_t q2[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] regval(input logic [4:0] n);
      if (n == 5'd1) return 32'hFFFFFFE2;
      if (n == 5'd2) return 32'h00000038;
      return {27'd0, n};
   endfunction

   function automatic logic [7:0] hex_ascii(input logic [3:0] n);
      if (n < 4'd10) return 8'h30 + {4'h0, n};
      return 8'h41 + ({4'h0, n} - 8'd10);
   endfunction

   task automatic push_reg(input int which, input int r, input int nchars);
      logic [31:0] v;
      ch_t e;
      v = regval(5'(r));
      for (int k = 0; k < nchars; k++) begin
         e.row  = 5'(r);
         e.col  = 7'(4 + k);
         e.code = hex_ascii(v[31-4*k -: 4]);
         if (which == 1) q1.push_back(e);
         else            q2.push_back(e);
      end
   endtask

   // Register file model: data is only valid in the exact cycle the scanner should sample it.
   int since1 = 0, since2 = 0, falls1 = 0, falls2 = 0;
   logic [4:0] lat1, lat2;
   always @(negedge clock) begin
      if (b1.dbg_clock === 1'b0) begin
         since1++;
         if (since1 == 1) begin lat1 = b1.dbg_read_address; falls1++; end
      end else since1 = 0;
      b1.dbg_data = (since1 == 1) ? regval(lat1) : 32'hBAD0BAD0;
      if (b2.dbg_clock === 1'b0) begin
         since2++;
         if (since2 == 1) begin lat2 = b2.dbg_read_address; falls2++; end
         else if (since2 <= 4) check("addr_stable2", 64'(b2.dbg_read_address), 64'(lat2));
      end else since2 = 0;
      b2.dbg_data = (since2 == 4) ? regval(lat2) : 32'hBAD0BAD0;
   end

   initial begin
      b1.char_ready = 1'b1;
      b2.char_ready = 1'b1;
      forever begin
         @(posedge clock);
         #1;
         b1.char_ready = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   // Monitors
   ch_t prev1, cur1, cur2;
   logic stall1 = 1'b0;
   int writes1 = 0, stalls1 = 0, done_cnt1 = 0, writes2 = 0, done_cnt2 = 0;
   logic [63:0] text1 [32];
   always @(negedge clock) begin
      if (b1.char_valid === 1'b1) begin
         cur1 = '{b1.char_row, b1.char_col, b1.char_code};
         if (stall1) check("hold_during_stall", 64'(cur1), 64'(prev1));
         if (b1.char_ready) begin
            int ci;
            writes1++;
            if (q1.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_write1 actual=%0h required=none", cur1);
            end else check("char1", 64'(cur1), 64'(q1.pop_front()));
            ci = int'(b1.char_col);
            if (ci >= 4 && ci < 12) text1[b1.char_row][8*(11-ci) +: 8] = b1.char_code;
         end else stalls1++;
         stall1 = !b1.char_ready;
         prev1  = cur1;
      end else stall1 = 1'b0;
      if (done1 === 1'b1) done_cnt1++;
      if (b2.char_valid === 1'b1) begin
         cur2 = '{b2.char_row, b2.char_col, b2.char_code};
         writes2++;
         if (q2.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_write2 actual=%0h required=none", cur2);
         end else check("char2", 64'(cur2), 64'(q2.pop_front()));
      end
      if (done2 === 1'b1) done_cnt2++;
   end

   task automatic run_sweep1(input bit rnd, input bit poke, input string tag);
      int s, n, dcyc;
      bit got;
      writes1 = 0; falls1 = 0; stalls1 = 0; done_cnt1 = 0;
      rand_mode = rnd;
      @(negedge clock); start1 = 1'b1; s = cyc + 1;
      @(negedge clock); start1 = 1'b0;
      n = 0; got = 1'b0; dcyc = 0;
      while (!got && n < 4000) begin
         @(negedge clock);
         n++;
         start1 = poke && (cyc == s + 50);
         if (done1) begin
            got = 1'b1; dcyc = cyc;
            start1 = poke;
         end
      end
      @(negedge clock); start1 = 1'b0;
      rand_mode = 1'b0;
      if (!got) begin
         checks++; errors++;
         $display("FAIL %s_done_timeout actual=none required=done", tag);
      end else check({tag, "_done_latency"}, 64'(dcyc - s), 64'(384 + stalls1));
      repeat (20) @(negedge clock);
      check({tag, "_writes"}, 64'(writes1), 64'd256);
      check({tag, "_falls"}, 64'(falls1), 64'd32);
      check({tag, "_done_count"}, 64'(done_cnt1), 64'd1);
      check({tag, "_queue_empty"}, 64'(q1.size()), 64'd0);
      check({tag, "_busy_low"}, 64'(busy1), 64'd0);
   endtask

   initial begin
      int n, s2, d2;
      bit found, got;
      reset = 1'b0; start1 = 1'b0; start2 = 1'b0;
      repeat (3) @(negedge clock);
      check("rst_char_valid", 64'(b1.char_valid), 64'd0);
      check("rst_dbg_clock", 64'(b1.dbg_clock), 64'd1);
      check("rst_busy", 64'(busy1), 64'd0);
      check("rst_done", 64'(done1), 64'd0);
      check("rst_addr", 64'(b1.dbg_read_address), 64'd0);
      check("rst_row", 64'(b1.char_row), 64'd0);
      check("rst_col", 64'(b1.char_col), 64'd0);
      check("rst_code", 64'(b1.char_code), 64'd0);
      reset = 1'b1;
      repeat (3) @(negedge clock);

      // Sweep with ready high; extra starts mid-sweep and in the done cycle must be dropped.
      for (int r = 0; r < 32; r++) push_reg(1, r, 8);
      run_sweep1(1'b0, 1'b1, "sweepA");
      check("row1_text", text1[1], 64'h4646464646464532);
      check("row2_text", text1[2], 64'h3030303030303338);
      check("row31_text", text1[31], 64'h3030303030303146);

      // Fresh sweep from idle with char_ready toggling.
      for (int r = 0; r < 32; r++) push_reg(1, r, 8);
      run_sweep1(1'b1, 1'b0, "sweepB");
      check("stalls_seen", 64'(stalls1 > 0), 64'd1);

      // Reset while register 10 nibble 3 is being presented.
      for (int r = 0; r < 10; r++) push_reg(1, r, 8);
      push_reg(1, 10, 3);
      writes1 = 0;
      @(negedge clock); start1 = 1'b1;
      @(negedge clock); start1 = 1'b0;
      n = 0; found = 1'b0;
      while (!found && n < 2000) begin
         @(posedge clock); #2; n++;
         if (b1.char_valid && b1.char_row == 5'd10 && b1.char_col == 7'd7) found = 1'b1;
      end
      check("reset_point_found", 64'(found), 64'd1);
      reset = 1'b0;
      #1;
      check("arst_char_valid", 64'(b1.char_valid), 64'd0);
      check("arst_dbg_clock", 64'(b1.dbg_clock), 64'd1);
      check("arst_busy", 64'(busy1), 64'd0);
      repeat (3) @(negedge clock);
      reset = 1'b1;
      repeat (30) @(negedge clock);
      check("arst_writes", 64'(writes1), 64'd83);
      check("arst_queue_empty", 64'(q1.size()), 64'd0);
      check("arst_idle_busy", 64'(busy1), 64'd0);

      // Second instance: 8 registers, settle 4 cycles.
      for (int r = 0; r < 8; r++) push_reg(2, r, 8);
      writes2 = 0; falls2 = 0; done_cnt2 = 0;
      @(negedge clock); start2 = 1'b1; s2 = cyc + 1;
      @(negedge clock); start2 = 1'b0;
      n = 0; got = 1'b0; d2 = 0;
      while (!got && n < 1000) begin
         @(negedge clock); n++;
         if (done2) begin got = 1'b1; d2 = cyc; end
      end
      if (!got) begin
         checks++; errors++;
         $display("FAIL dut2_done_timeout actual=none required=done");
      end else check("dut2_done_latency", 64'(d2 - s2), 64'd120);
      repeat (20) @(negedge clock);
      check("dut2_writes", 64'(writes2), 64'd64);
      check("dut2_falls", 64'(falls2), 64'd8);
      check("dut2_done_count", 64'(done_cnt2), 64'd1);
      check("dut2_queue_empty", 64'(q2.size()), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog expired");
   end
endmodule

// File: doc/regfile_debug_scanner.md
Name: regfile_debug_scanner

Overview:
- Reader for the register file's debug port in the VGA demo.
- On a start pulse, it sweeps registers 0..NUM_REGS-1 through that port. It drives the read address and generates the debug read strobe.
- Each captured 32-bit word is converted to 8 ASCII hex characters. These are written into the VGA text buffer at row = register index, columns COL_BASE..COL_BASE+7.
- It sits between the register file debug port and the character RAM write port. Single clock domain.

Parameters:
- NUM_REGS, 32: number of registers swept. Range 1..32.
- COL_BASE, 4: text column of the most significant hex digit.
- SETTLE_CYCLES, 1: cycles waited after the strobe falling edge before sampling debug data. Range 1..15.

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to begin a full sweep; ignored while busy.
- dbg_read_address  out  5  register address presented to the debug port.
- dbg_clock  out  1  registered debug strobe; the register file samples on its falling edge.
- dbg_data  in  32  debug read data from the register file.
- char_valid  out  1  character write request.
- char_ready  in  1  text buffer accepts the write when valid and ready are both high.
- char_row  out  5  text row (= register index).
- char_col  out  7  text column.
- char_code  out  8  ASCII code of the character.
- busy  out  1  high from the cycle after start is accepted until the sweep completes.
- done  out  1  one-cycle pulse at the end of a sweep.

Behaviour:
- Reset values (reset low, asynchronous): state IDLE, index 0, nibble counter 0, data register 0, dbg_read_address 0, dbg_clock 1, char_valid 0, char_row 0, char_col 0, char_code 0, busy 0, done 0.
- Reset asserted mid-sweep aborts immediately; no further character writes occur. After release the block waits in IDLE for a new start.
- States and transitions:
  - IDLE: if start, index<=0, busy<=1, go to ADDR.
  - ADDR: dbg_read_address<=index, dbg_clock<=1; go to STROBE.
  - STROBE: dbg_clock<=0 (falling edge = register file read); go to WAIT with settle counter = SETTLE_CYCLES.
  - WAIT: decrement the counter. At 1, data register<=dbg_data, nibble<=0, go to EMIT.
  - EMIT: char_valid=1. char_row=index, char_col=COL_BASE+nibble, char_code=hex(data[31-4*nibble -: 4]), most significant nibble first.
    - On a valid&&ready cycle: nibble<=nibble+1. After nibble 7 is accepted, char_valid<=0 and go to NEXT.
    - While ready is low, valid, row, col and code hold stable.
  - NEXT: dbg_clock<=1.
    - If index==NUM_REGS-1: done<=1 for one cycle, busy<=0, go to IDLE.
    - Else index<=index+1 and go to ADDR.
- Hex encoding: nibble 0-9 maps to 8'h30+n; nibble 10-15 maps to 8'h41+(n-10), i.e. uppercase A-F.
- dbg_clock produces exactly one falling edge per register. No glitches; driven directly from a flop.
- start arriving while busy, or in the same cycle done is high, is ignored and not queued.
- Latency with char_ready tied high and SETTLE_CYCLES=1:
  - 12 cycles per register (ADDR, STROBE, WAIT, 8×EMIT, NEXT).
  - busy rises on the edge that samples start; done pulses 384 cycles after that edge for NUM_REGS=32.
- Register 0 is swept like any other; it displays whatever the register file returns.

Test Plan:
- Register file model with reg1=32'hFFFFFFE2, reg2=32'h00000038, regN=N otherwise; pulse start, char_ready=1.
  - Row 1, cols 4..11 must receive "FFFFFFE2". Row 2 must receive "00000038". Row 31 must receive "0000001F".
  - Exactly 256 writes occur; done pulses once, 384 cycles after start.
- Toggle char_ready pseudo-randomly at 50%.
  - Same 256 characters, in the same order.
  - row/col/code never change while valid is high and ready is low.
  - done is delayed by exactly the number of stalled cycles.
- Count dbg_clock falling edges per sweep: must equal 32.
  - dbg_read_address must be stable from ADDR through WAIT.
  - Captured words must match the model at each edge.
- Pulse start at cycle 50 of a sweep and again in the done cycle.
  - No restart or second sweep is triggered.
  - A later start in IDLE starts a fresh sweep from row 0.
- Assert reset low during EMIT of register 10, nibble 3.
  - All outputs go to reset values asynchronously: char_valid=0, dbg_clock=1, busy=0.
  - After release, no writes occur until start.
- Set SETTLE_CYCLES=4 and NUM_REGS=8.
  - Sampling occurs 4 cycles after each falling edge.
  - done pulses after 8×15=120 cycles; rows 0..7 only.
